// File: rtl/cache_refill.sv
// AXI4 refill/writeback engine for the cache line array.
// Writes back a dirty victim as one INCR burst, then fetches and assembles the new line.
module cache_refill #(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned OFFSET_W   = 5
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     miss_req,
  input  logic [31:0]              miss_addr,
  input  logic                     miss_dirty,
  input  logic [31:0]              wb_addr,
  input  logic [LINE_WORDS*32-1:0] cacheline_old,
  output logic                     busy,
  output logic                     refill_done,
  output logic [LINE_WORDS*32-1:0] cacheline_new,
  output logic [31:0]              awaddr,
  output logic [7:0]               awlen,
  output logic [2:0]               awsize,
  output logic [1:0]               awburst,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [31:0]              wdata,
  output logic [3:0]               wstrb,
  output logic                     wlast,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic                     bvalid,
  output logic                     bready,
  output logic [31:0]              araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [31:0]              rdata,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready
);

  localparam int unsigned CNT_W = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_AR,
    S_R,
    S_DONE
  } state_e;

  typedef logic [LINE_WORDS-1:0][31:0] line_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      araddr_q, araddr_d;
  logic [31:0]      awaddr_q, awaddr_d;
  line_t            old_q, old_d;
  line_t            new_q, new_d;

  // Beat completion is tracked by the counter alone, so rlast is never consulted.
  logic unused_ok;
  assign unused_ok = ^{miss_addr[OFFSET_W-1:0], wb_addr[OFFSET_W-1:0], rlast};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      araddr_q <= '0;
      awaddr_q <= '0;
      old_q    <= '0;
      new_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      araddr_q <= araddr_d;
      awaddr_q <= awaddr_d;
      old_q    <= old_d;
      new_q    <= new_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    araddr_d = araddr_q;
    awaddr_d = awaddr_q;
    old_d    = old_q;
    new_d    = new_q;
    case (state_q)
      S_IDLE: begin
        if (miss_req) begin
          araddr_d = {miss_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
          awaddr_d = {wb_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
          old_d    = cacheline_old;
          cnt_d    = '0;
          state_d  = miss_dirty ? S_AW : S_AR;
        end
      end
      S_AW: if (awready) state_d = S_W;
      S_W: begin
        if (wready) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = S_B;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_B:  if (bvalid) state_d = S_AR;
      S_AR: if (arready) state_d = S_R;
      S_R: begin
        if (rvalid) begin
          new_d[cnt_q] = rdata;
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Channel valids/readies decode directly from the state register.
  assign busy          = (state_q != S_IDLE);
  assign refill_done   = (state_q == S_DONE);
  assign cacheline_new = new_q;

  assign awaddr  = awaddr_q;
  assign awlen   = 8'(LINE_WORDS - 1);
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign awvalid = (state_q == S_AW);

  assign wdata  = old_q[cnt_q];
  assign wstrb  = 4'hf;
  assign wlast  = (state_q == S_W) && (cnt_q == LAST_BEAT);
  assign wvalid = (state_q == S_W);

  assign bready = (state_q == S_B);

  assign araddr  = araddr_q;
  assign arlen   = 8'(LINE_WORDS - 1);
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arvalid = (state_q == S_AR);

  assign rready = (state_q == S_R);

endmodule
